// File: rtl/mux_rr_select.sv
// Round-robin select generator for the 4:1 case mux; each grant dwells HOLD cycles.
// Optional feature: define MUX_SEL_EARLY_RELEASE_EN to release a grant as soon as its request drops.
module mux_rr_select #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       new_grant
);

  localparam int CNT_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       any_req;
  logic       release_now;
  logic       start_grant;

  // First asserted request found searching upward from ptr, wrapping mod 4.
  always_comb begin
    winner = ptr;
    idx    = ptr;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

`ifdef MUX_SEL_EARLY_RELEASE_EN
  assign release_now = (cnt == '0) || !req[sel];
`else
  assign release_now = (cnt == '0);
`endif

  assign start_grant = any_req && ((state == IDLE) || release_now);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      sel       <= 2'd0;
      grant     <= 4'd0;
      busy      <= 1'b0;
      new_grant <= 1'b0;
    end else begin
      new_grant <= 1'b0;
      if (start_grant) begin
        state     <= GRANT;
        sel       <= winner;
        grant     <= 4'b0001 << winner;
        busy      <= 1'b1;
        new_grant <= 1'b1;
        cnt       <= CNT_LOAD;
        ptr       <= winner + 2'd1;
      end else if (state == GRANT) begin
        if (release_now) begin
          // Nobody is waiting: drop the grant but keep sel so the mux output stays put.
          state <= IDLE;
          busy  <= 1'b0;
          grant <= 4'd0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_select.sv
// Scoreboard bench for mux_rr_select: two instances (HOLD=4 and HOLD=1) share one random req stream.
// Honours MUX_SEL_EARLY_RELEASE_EN so the reference model matches the build.
module tb_mux_rr_select;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'd0;

  logic [1:0] sel0, sel1;
  logic [3:0] grant0, grant1;
  logic       busy0, busy1, ng0, ng1;

  int checks = 0;
  int errors = 0;

`ifdef MUX_SEL_EARLY_RELEASE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  mux_rr_select #(.HOLD(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel0), .grant(grant0), .busy(busy0), .new_grant(ng0)
  );

  mux_rr_select #(.HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel1), .grant(grant1), .busy(busy1), .new_grant(ng1)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       ng;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference state: remaining cycles of the current grant, not a hardware counter.
  int m_busy[2];
  int m_sel[2];
  int m_ptr[2];
  int m_rem[2];
  int m_ng[2];
  int hold_of[2] = '{4, 1};

  // Mux data inputs a, b, c, d as seen by the downstream case mux.
  logic [1:0] mux_data[4] = '{2'b00, 2'b01, 2'b11, 2'b00};

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_sel[k] = 0; m_ptr[k] = 0; m_rem[k] = 0; m_ng[k] = 0;
    end
  endfunction

  function automatic void model_step(input int k, input logic [3:0] r);
    bit rel;
    int c;
    m_ng[k] = 0;
    if (m_busy[k] != 0) begin
      rel = (m_rem[k] == 1) || (EARLY && !r[m_sel[k]]);
      if (!rel) begin
        m_rem[k] = m_rem[k] - 1;
        return;
      end
      if (r == 4'd0) begin
        m_busy[k] = 0;
        return;
      end
    end else if (r == 4'd0) begin
      return;
    end
    for (int n = 0; n < 4; n++) begin
      c = (m_ptr[k] + n) % 4;
      if (r[c]) begin
        m_sel[k]  = c;
        m_ptr[k]  = (c + 1) % 4;
        m_rem[k]  = hold_of[k];
        m_busy[k] = 1;
        m_ng[k]   = 1;
        break;
      end
    end
  endfunction

  function automatic exp_t model_out(input int k);
    exp_t e;
    e.sel   = 2'(m_sel[k]);
    e.grant = (m_busy[k] != 0) ? (4'b0001 << m_sel[k]) : 4'd0;
    e.busy  = (m_busy[k] != 0);
    e.ng    = (m_ng[k] != 0);
    return e;
  endfunction

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      req = r;
    end
  endtask

  // Expected responses are produced on the same edge the DUT samples req.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, req);
      model_step(1, req);
      q0.push_back(model_out(0));
      q1.push_back(model_out(1));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check_output("h4_sel",   8'(sel0),   8'(e.sel));
        check_output("h4_grant", 8'(grant0), 8'(e.grant));
        check_output("h4_busy",  8'(busy0),  8'(e.busy));
        check_output("h4_newg",  8'(ng0),    8'(e.ng));
        if (e.busy)
          check_output("h4_muxout", 8'(mux_data[sel0]), 8'(mux_data[e.sel]));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check_output("h1_sel",   8'(sel1),   8'(e.sel));
        check_output("h1_grant", 8'(grant1), 8'(e.grant));
        check_output("h1_busy",  8'(busy1),  8'(e.busy));
        check_output("h1_newg",  8'(ng1),    8'(e.ng));
      end
    end
  end

  task automatic async_reset_check();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_sel",   8'(sel0),   8'd0);
    check_output("rst_grant", 8'(grant0), 8'd0);
    check_output("rst_busy",  8'(busy0),  8'd0);
    check_output("rst_newg",  8'(ng0),    8'd0);
    check_output("rst_grant1", 8'(grant1), 8'd0);
    check_output("rst_busy1", 8'(busy1),  8'd0);
    q0.delete();
    q1.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'd0;
    repeat (3) @(negedge clk);
    check_output("init_sel",   8'(sel0),   8'd0);
    check_output("init_grant", 8'(grant0), 8'd0);
    check_output("init_busy",  8'(busy0),  8'd0);
    check_output("init_newg",  8'(ng0),    8'd0);
    rst_n = 1'b1;

    apply_stimulus(4'b0100, 12);
    apply_stimulus(4'b0000, 8);
    apply_stimulus(4'b1111, 22);
    apply_stimulus(4'b1010, 18);
    apply_stimulus(4'b0000, 4);

    apply_stimulus(4'b1111, 3);
    async_reset_check();
    req   = 4'b1111;
    rst_n = 1'b1;
    apply_stimulus(4'b1111, 10);

    async_reset_check();
    req   = 4'b0011;
    rst_n = 1'b1;
    apply_stimulus(4'b0011, 1);
    apply_stimulus(4'b0010, 8);
    apply_stimulus(4'b0000, 4);

    for (int i = 0; i < 120; i++) begin
      apply_stimulus(4'($urandom), 1 + int'($urandom_range(5)));
    end

    apply_stimulus(4'b0000, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
